// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: fetch control and decode handshake, plus the instruction memory port.
// The master modport is the fetch unit, and the slave modport is its environment.
interface instr_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 16
) ();
    logic              i_en;
    logic              i_branch;
    logic [ADDR_W-1:0] i_branch_target;
    logic              i_ready;
    logic [ADDR_W-1:0] o_pc;
    logic [INST_W-1:0] i_inst;
    logic              o_valid;
    logic [INST_W-1:0] o_inst;
    logic [ADDR_W-1:0] o_inst_pc;

    modport master (
        input  i_en, i_branch, i_branch_target, i_ready, i_inst,
        output o_pc, o_valid, o_inst, o_inst_pc
    );

    modport slave (
        output i_en, i_branch, i_branch_target, i_ready, i_inst,
        input  o_pc, o_valid, o_inst, o_inst_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one read in flight against a 1-cycle-latency memory,
// a registered output to decode, branch redirect with flush, and stall replay.
module instr_fetch #(
    parameter int ADDR_W    = 32,
    parameter int INST_W    = 16,
    parameter int MEM_DEPTH = 4,
    parameter int RESET_PC  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_ADDR = ADDR_W'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

    // Sequential increment that wraps at the memory depth, not at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] inc_addr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        if (a == LAST_ADDR) begin
            r = '0;
        end else begin
            r = a + ADDR_W'(1);
        end
        return r;
    endfunction

    // Branch targets outside the memory range are redirected to address 0.
    function automatic logic [ADDR_W-1:0] legal_target(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        if (a < DEPTH_ADDR) begin
            r = a;
        end else begin
            r = '0;
        end
        return r;
    endfunction

    logic [ADDR_W-1:0] pc_r, pc_nxt_s;
    logic              f_vld_r, f_vld_nxt_s;
    logic [ADDR_W-1:0] f_pc_r, f_pc_nxt_s;
    logic              out_valid_r, out_valid_nxt_s;
    logic [INST_W-1:0] out_inst_r, out_inst_nxt_s;
    logic [ADDR_W-1:0] out_pc_r, out_pc_nxt_s;
    logic              advance_s;
    logic [ADDR_W-1:0] tgt_s;

    assign advance_s = !out_valid_r || bus.i_ready;
    assign tgt_s     = legal_target(bus.i_branch_target);

    // Memory address: a branch wins, a stall replays the in-flight address.
    always_comb begin
        bus.o_pc = pc_r;
        if (bus.i_branch) begin
            bus.o_pc = tgt_s;
        end else if (advance_s) begin
            bus.o_pc = pc_r;
        end else begin
            bus.o_pc = f_pc_r;
        end
    end

    // Next-state logic for the fetch pointer, the in-flight read and the output register.
    always_comb begin
        pc_nxt_s        = pc_r;
        f_vld_nxt_s     = f_vld_r;
        f_pc_nxt_s      = f_pc_r;
        out_valid_nxt_s = out_valid_r;
        out_inst_nxt_s  = out_inst_r;
        out_pc_nxt_s    = out_pc_r;
        if (bus.i_branch) begin
            out_valid_nxt_s = 1'b0;
            f_vld_nxt_s     = 1'b1;
            f_pc_nxt_s      = tgt_s;
            pc_nxt_s        = inc_addr(tgt_s);
        end else if (advance_s) begin
            out_valid_nxt_s = f_vld_r;
            out_inst_nxt_s  = bus.i_inst;
            out_pc_nxt_s    = f_pc_r;
            if (bus.i_en) begin
                f_vld_nxt_s = 1'b1;
                f_pc_nxt_s  = pc_r;
                pc_nxt_s    = inc_addr(pc_r);
            end else begin
                f_vld_nxt_s = 1'b0;
            end
        end else begin
            // Hold: decode is stalled, and the memory keeps returning the same word.
            pc_nxt_s    = pc_r;
            f_vld_nxt_s = f_vld_r;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r        <= RESET_ADDR;
            f_vld_r     <= 1'b0;
            f_pc_r      <= '0;
            out_valid_r <= 1'b0;
            out_inst_r  <= '0;
            out_pc_r    <= '0;
        end else begin
            pc_r        <= pc_nxt_s;
            f_vld_r     <= f_vld_nxt_s;
            f_pc_r      <= f_pc_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_inst_r  <= out_inst_nxt_s;
            out_pc_r    <= out_pc_nxt_s;
        end
    end

    assign bus.o_valid   = out_valid_r;
    assign bus.o_inst    = out_inst_r;
    assign bus.o_inst_pc = out_pc_r;
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch with a 4-word memory {A0..A3} and a 1-cycle read latency.
module tb_instr_fetch;
    localparam logic [15:0] A0 = 16'hA0A0;
    localparam logic [15:0] A1 = 16'hA1A1;
    localparam logic [15:0] A2 = 16'hA2A2;
    localparam logic [15:0] A3 = 16'hA3A3;

    typedef struct {
        logic [15:0] inst;
        logic [31:0] pc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    exp_t sb_q[$];

    instr_fetch_if #(.ADDR_W(32), .INST_W(16)) bus ();

    instr_fetch #(.ADDR_W(32), .INST_W(16), .MEM_DEPTH(4), .RESET_PC(0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        logic [15:0] w;
        case (a)
            32'd0:   w = A0;
            32'd1:   w = A1;
            32'd2:   w = A2;
            32'd3:   w = A3;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // The memory model has a 1-cycle read latency.
    always @(posedge clk) bus.i_inst <= mem_word(bus.o_pc);

    // Monitor: every transfer to decode is compared with the next expected word.
    always @(negedge clk) begin
        if (rst_n && bus.o_valid && bus.i_ready) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_xfer: got inst %h pc %0d, expected nothing", bus.o_inst, bus.o_inst_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (bus.o_inst !== e.inst || bus.o_inst_pc !== e.pc) begin
                    n_err++;
                    $display("FAIL xfer: got inst %h pc %0d, expected inst %h pc %0d",
                             bus.o_inst, bus.o_inst_pc, e.inst, e.pc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] inst, input logic [31:0] pc);
        exp_t e;
        e.inst = inst;
        e.pc   = pc;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_branch = 1'b0;
        bus.i_en = 1'b1;
        bus.i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic end_scenario(input string name);
        @(negedge clk);
        #1;
        check({name, "_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.i_en = 1'b1;
        bus.i_ready = 1'b1;
        bus.i_branch = 1'b0;
        bus.i_branch_target = 32'd0;
        #1;
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_inst", 32'(bus.o_inst), 32'd0);
        check("rst_inst_pc", bus.o_inst_pc, 32'd0);
        check("rst_pc", bus.o_pc, 32'd0);

        // Straight-line fetch with wrap after word 3.
        do_reset();
        push(A0, 32'd0); push(A1, 32'd1); push(A2, 32'd2); push(A3, 32'd3); push(A0, 32'd0);
        tick();
        check("first_edge_valid", 32'(bus.o_valid), 32'd0);
        tick();
        check("second_edge_valid", 32'(bus.o_valid), 32'd1);
        repeat (4) tick();
        end_scenario("seq");

        // Decode stall of three cycles while A1 is held.
        do_reset();
        push(A0, 32'd0); push(A1, 32'd1); push(A2, 32'd2); push(A3, 32'd3);
        repeat (3) tick();
        bus.i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_inst", 32'(bus.o_inst), 32'(A1));
            check("hold_valid", 32'(bus.o_valid), 32'd1);
            check("hold_pc_replay", bus.o_pc, 32'd2);
        end
        bus.i_ready = 1'b1;
        repeat (2) tick();
        end_scenario("hold");

        // Branch to 3 while A0 is presented.
        do_reset();
        push(A0, 32'd0); push(A3, 32'd3); push(A0, 32'd0);
        repeat (2) tick();
        bus.i_branch = 1'b1;
        bus.i_branch_target = 32'd3;
        tick();
        bus.i_branch = 1'b0;
        check("branch_flush", 32'(bus.o_valid), 32'd0);
        tick();
        check("branch_tgt_inst", 32'(bus.o_inst), 32'(A3));
        tick();
        end_scenario("branch");

        // Out-of-range branch target redirects to 0.
        do_reset();
        push(A0, 32'd0); push(A0, 32'd0); push(A1, 32'd1);
        repeat (2) tick();
        bus.i_branch = 1'b1;
        bus.i_branch_target = 32'd9;
        #1;
        check("branch_oob_pc", bus.o_pc, 32'd0);
        tick();
        bus.i_branch = 1'b0;
        check("branch_oob_flush", 32'(bus.o_valid), 32'd0);
        repeat (2) tick();
        end_scenario("branch_oob");

        // Fetch enable dropped for two cycles.
        do_reset();
        push(A0, 32'd0); push(A1, 32'd1); push(A2, 32'd2); push(A3, 32'd3);
        repeat (2) tick();
        bus.i_en = 1'b0;
        tick();
        check("en_inflight_inst", 32'(bus.o_inst), 32'(A1));
        tick();
        check("en_gap1", 32'(bus.o_valid), 32'd0);
        bus.i_en = 1'b1;
        tick();
        check("en_gap2", 32'(bus.o_valid), 32'd0);
        repeat (2) tick();
        end_scenario("enable");

        // Asynchronous reset during a hold with A2 on the output.
        do_reset();
        push(A0, 32'd0); push(A1, 32'd1);
        repeat (4) tick();
        bus.i_ready = 1'b0;
        tick();
        check("pre_rst_inst", 32'(bus.o_inst), 32'(A2));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.o_valid), 32'd0);
        check("midrst_inst", 32'(bus.o_inst), 32'd0);
        check("midrst_inst_pc", bus.o_inst_pc, 32'd0);
        check("midrst_pc", bus.o_pc, 32'd0);
        check("midrst_drained", 32'(sb_q.size()), 32'd0);
        do_reset();
        push(A0, 32'd0); push(A1, 32'd1);
        repeat (2) tick();
        check("post_rst_inst", 32'(bus.o_inst), 32'(A0));
        tick();
        end_scenario("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
